// File: rtl/pipelined_add_sub_pkg.sv
// Shared helpers for the pipelined adder/subtractor: slice sizing, parameter
// legality, the full-adder cell and a result record for downstream ALU blocks.
package pipelined_add_sub_pkg;

  localparam int unsigned DefaultWidth = 16;

  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  typedef struct packed {
    logic [DefaultWidth-1:0] sum;
    logic                    cout;
    logic                    ovf;
  } add_result_t;

endpackage

// File: rtl/add_slice.sv
// Combinational ripple-carry slice built from full-adder cells; also exposes the
// carry into its MSB so the top can derive signed overflow.
module add_slice
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             cin_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  always_comb begin
    logic [Width:0] carry;
    logic [1:0]     fa;
    carry    = '0;
    fa       = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < Width; i++) begin
      fa           = full_add(a_i[i], b_i[i], carry[i]);
      sum_o[i]     = fa[0];
      carry[i+1]   = fa[1];
    end
    cout_o = carry[Width];
    cmsb_o = carry[Width-1];
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Carry-chain-pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
// Define PIPELINED_ADD_SUB_OVF_EN to add the registered signed-overflow output OVF.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  input  logic             SUB,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             O_VALID,
  input  logic             O_READY
`ifdef PIPELINED_ADD_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned SliceW = slice_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // The whole pipeline moves in lockstep; only a blocked output stalls it.
  logic adv;
  assign adv     = ~O_VALID | O_READY;
  assign I_READY = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Rem  = WIDTH - k * SliceW;  // operand bits not yet summed
    localparam int unsigned Done = (k + 1) * SliceW;    // result bits known after this stage

    logic [Rem-1:0]    a_in, b_in;
    logic              cin_in, v_in;
    logic [SliceW-1:0] slice_sum;
    logic              slice_cout, slice_cmsb;
    logic [Done-1:0]   s_new;
    logic              v_d, v_q, c_d, c_q;
    logic [Done-1:0]   s_d, s_q;

    if (k == 0) begin : g_head
      // Subtract as I0 + ~I1 + 1; CIN is ignored in that case.
      assign a_in   = I0;
      assign b_in   = SUB ? ~I1 : I1;
      assign cin_in = SUB | CIN;
      assign v_in   = I_VALID;
      assign s_new  = slice_sum;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign cin_in = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_new  = {slice_sum, g_stage[k-1].s_q};
    end

    add_slice #(
      .Width(SliceW)
    ) u_slice (
      .cin_i (cin_in),
      .a_i   (a_in[SliceW-1:0]),
      .b_i   (b_in[SliceW-1:0]),
      .sum_o (slice_sum),
      .cout_o(slice_cout),
      .cmsb_o(slice_cmsb)
    );

    // Data only loads on a valid beat so the final stage holds its last result.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_in;
        if (v_in) begin
          c_d = slice_cout;
          s_d = s_new;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [Rem-SliceW-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv && v_in) begin
          a_d = a_in[Rem-1:SliceW];
          b_d = b_in[Rem-1:SliceW];
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef PIPELINED_ADD_SUB_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv && v_in) ovf_d = slice_cmsb ^ slice_cout;
      end

      always_ff @(posedge CLK) begin
        if (RESET) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
      end
    end else begin : g_tie
      logic unused_cmsb;
      assign unused_cmsb = slice_cmsb;
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
`endif
  end

  assign O       = g_stage[STAGES-1].s_q;
  assign COUT    = g_stage[STAGES-1].c_q;
  assign O_VALID = g_stage[STAGES-1].v_q;
`ifdef PIPELINED_ADD_SUB_OVF_EN
  assign OVF     = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised N-bit adder/subtractor, successor to the fixed 8-bit ripple-carry adder.
- Carry chain is split into STAGES equal slices with a register between slices, so timing closes at higher fabric clock rates.
- Valid/ready streaming handshake on both sides; per-transaction ADD/SUB select; carry-in and carry-out are exposed.
- Sits in datapaths (counters, ALUs, DSP accumulators) that need wide adds at full clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of carry-chain slices, equal to the pipeline latency in cycles; 1 <= STAGES <= WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- I0  input  WIDTH  operand A.
- I1  input  WIDTH  operand B.
- CIN  input  1  carry-in; ignored when SUB=1.
- SUB  input  1  0: O = I0 + I1 + CIN; 1: O = I0 - I1.
- I_VALID  input  1  input beat valid.
- I_READY  output  1  block accepts a beat this cycle.
- O  output  WIDTH  result, modulo 2^WIDTH.
- COUT  output  1  carry out of the MSB; for SUB this is the not-borrow flag (1 when I0 >= I1 unsigned).
- O_VALID  output  1  result valid.
- O_READY  input  1  downstream accepts the result.

Behaviour:
- Slice width C = WIDTH/STAGES. Slice k covers bits [k*C +: C] and is computed in pipeline stage k.
- SUB=1 is implemented as I0 + ~I1 + 1: I1 is inverted and the carry-in is forced to 1 at capture.
- Stage 0 computes slice 0 combinationally from the captured inputs and registers: slice-0 sum, carry, remaining operand slices, and valid bit.
- Stage k (k >= 1) computes slice k from the operand bits skewed through k registers plus the registered carry of stage k-1.
- Lower result slices are delayed through de-skew registers so that all of O appears aligned in the final stage.
- Latency is exactly STAGES cycles from an accepted input beat (I_VALID & I_READY) to O_VALID, assuming no stall.
- Throughput is one beat per cycle.
- Pipeline advance: adv = ~O_VALID | O_READY. When adv=1, every stage shifts by one; when adv=0, every stage holds its contents.
- I_READY = adv. I_READY is combinational from O_VALID/O_READY only and never depends on I_VALID.
- Bubbles: a stage whose valid bit is 0 still shifts, but its data is don't-care. O and COUT are held at their last valid values while O_VALID=0.
- Stall: while O_VALID=1 and O_READY=0, O, COUT and O_VALID are held stable every cycle, and no input beat is accepted.
- Simultaneous output drain and input accept in one cycle is legal and loses no beat.
- Reset: all stage valid bits clear to 0; O, COUT and all data registers clear to 0; I_READY=1 in the cycle after reset. Reset mid-operation discards every in-flight beat, with no partial output.
- STAGES=1: the block is a registered ripple adder with latency 1.
- STAGES=WIDTH: one bit per stage.
- Wrap-around: 0xFFFF + 0x0001 gives O=0x0000, COUT=1. No saturation.

Optional Feature:
- Macro PIPELINED_ADD_SUB_OVF_EN.
- When defined:
  - Adds output port OVF (1 bit), the signed two's-complement overflow flag: carry into MSB XOR carry out of MSB, computed in the final stage.
  - OVF is registered and aligned with O, reset to 0, and held under stall exactly like COUT.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pipelined_add_sub_pkg:
  - constant function for slice width (WIDTH/STAGES);
  - elaboration-time legality check (WIDTH % STAGES == 0, STAGES >= 1);
  - result struct typedef {sum, cout, ovf} reused by downstream ALU blocks.
- One sub-module: add_slice, a purely combinational C-bit ripple adder (CIN, I0, I1 in; sum, COUT, carry-into-MSB out) built from per-bit full-adder cells. It is instantiated STAGES times by generate.

Test Plan:
- Basic add, WIDTH=16, STAGES=4, O_READY=1: I0=0x1234, I1=0x1111, CIN=0, SUB=0 -> 4 cycles later O_VALID=1, O=0x2345, COUT=0.
- Carry propagation across all slices: I0=0xFFFF, I1=0x0000, CIN=1 -> O=0x0000, COUT=1. Then I0=0x00FF, I1=0x0001 -> O=0x0100, COUT=0.
- Subtract: I0=0x0005, I1=0x0007, SUB=1, CIN=1 (must be ignored) -> O=0xFFFE, COUT=0. I0=0x0007, I1=0x0005 -> O=0x0002, COUT=1.
- Backpressure: stream 8 back-to-back beats (I0=n, I1=n, n=0..7) while O_READY toggles 1,0,0,1,... -> outputs 0,2,4,...,14 appear in order, none dropped or duplicated. O is stable while O_VALID & ~O_READY, and I_READY=0 in exactly those cycles.
- Reset mid-flight: accept 3 beats, assert RESET for 1 cycle -> O_VALID=0 and O=0 next cycle, and no stale result ever emerges. Repeat the scenario with STAGES=1 and STAGES=16.
- With PIPELINED_ADD_SUB_OVF_EN: 0x7FFF + 0x0001 -> OVF=1, O=0x8000. 0x8000 - 0x0001 -> OVF=1. 0x0001 + 0x0001 -> OVF=0.
- Randomized scoreboard against (I0 ± I1 + CIN) mod 2^WIDTH for 10k beats at random I_VALID/O_READY.
